svnet_fifo_write_arbiter: RTL
=============================

// Module: svnet_fifo_write_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one svnet_ram_fifo write port among REQUESTERS producers.
//  Grants one producer at a time for a burst of up to MAX_BURST words.
//  Gates every write on the FIFO's free_space, so the FIFO write assertion (write |-> free_space) can never fire.
//  Sits between layer-output producers and the shared inter-layer FIFO.
// PARAMETERS
//  WIDTH       1  data word width; equals the FIFO WIDTH
//  DEPTH       1  FIFO depth; sets the free_space width
//  REQUESTERS  2  number of producers, >= 2
//  MAX_BURST   4  maximum words per grant, >= 1
// PORTS
//  clk              in   1                      clock, single domain
//  rst_n            in   1                      synchronous reset, active-low
//  req              in   REQUESTERS             producer i has a word available on req_data slice i
//  req_data         in   REQUESTERS*WIDTH       packed words; producer i occupies [i*WIDTH +: WIDTH]
//  ack              out  REQUESTERS             one-hot; word of producer i consumed this cycle
//  fifo_free_space  in   $clog2(DEPTH)+1        FIFO free_space
//  fifo_write       out  1                      FIFO write
//  fifo_write_data  out  WIDTH                  FIFO write_data
//  grant_id         out  max(1,$clog2(REQUESTERS))  current or last granted producer
//  busy             out  1                      1 while in state BURST
// BEHAVIOUR
//  Reset: state=IDLE, grant_id=0, last=REQUESTERS-1, count=0.
//   Outputs during reset: ack=0, fifo_write=0, busy=0. Requester 0 has first priority after reset.
//  State IDLE:
//   - Search order: last+1, last+2, ... wrapping to last. Pick the first i with req[i]=1.
//   - On a hit: grant_id<=i, last<=i, count<=0, go to BURST.
//   - No word is written in IDLE, so arbitration costs 1 cycle per grant.
//  State BURST (grant g=grant_id):
//   - Combinational write: fifo_write = req[g] && (fifo_free_space!=0).
//   - ack[g] = fifo_write. All other ack bits are 0.
//   - fifo_write_data = req_data[g] when fifo_write=1, else 0.
//   - On a write: count<=count+1. If count==MAX_BURST-1, go to IDLE (burst complete).
//   - req[g]=0: go to IDLE with no write that cycle; the burst ends early.
//   - req[g]=1 and free_space==0: stall in BURST and hold count. The grant is kept; there is no timeout.
//  Producers must hold req and req_data stable until ack. Dropping req before ack withdraws the word.
//  count width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.
//  last and grant_id wrap modulo REQUESTERS; out-of-range ids are never produced.
//  The FIFO updates free_space the cycle after a write.
//   - With free_space==1, at most one write occurs.
//   - The next cycle sees 0 and stalls.
//  Simultaneous requests are resolved by the round-robin order only. No requester is granted twice while another waits.
//  MAX_BURST==1: every word passes through IDLE, giving 50% peak throughput.
//  rst_n=0 mid-burst: the next edge forces IDLE. fifo_write drops that cycle; no partial state is kept.
// TESTING
//  1. Reset, req=4'b0001, free=8, MAX_BURST=4 -> writes 0,0,0,0 on cycles 2-5, then IDLE, re-grant, write at cycle 7.
//  2. req=4'b1111 held, free large -> grant order 0,1,2,3,0; 4 words each; busy low 1 cycle between bursts.
//  3. Grant 2, free_space=0 for 5 cycles -> fifo_write=0, ack=0, count held; resumes when free>0, total 4 words.
//  4. Grant 1 drops req after 2 words -> IDLE; next grant goes to 2 (if requesting) with last=1.
//  5. free_space=1, req held -> exactly one write, then stall; scoreboard FIFO contents and order vs producer streams.
//  6. rst_n low mid-burst at count=2 -> next cycle IDLE, grant_id=0, last=REQUESTERS-1; requester 0 served first.

Source files
------------

// File: rtl/svnet_fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQUESTERS producers.
// Each grant covers a burst of up to MAX_BURST words, and every write is gated on FIFO free space.
module svnet_fifo_write_arbiter #(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 1,
    parameter int REQUESTERS = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [REQUESTERS-1:0]                              req,
    input  logic [REQUESTERS*WIDTH-1:0]                        req_data,
    output logic [REQUESTERS-1:0]                              ack,
    input  logic [$clog2(DEPTH):0]                             fifo_free_space,
    output logic                                               fifo_write,
    output logic [WIDTH-1:0]                                   fifo_write_data,
    output logic [((REQUESTERS > 1) ? $clog2(REQUESTERS) : 1)-1:0] grant_id,
    output logic                                               busy
);

    localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   count_q, count_d;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            hit;
    logic            req_g;
    logic [WIDTH-1:0] data_g;

    // Lowest offset from last wins, so scan offsets from the far end down.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = '0;
        for (int k = REQUESTERS; k >= 1; k--) begin
            cand = GW'((int'(last_q) + k) % REQUESTERS);
            if (req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        req_g  = 1'b0;
        data_g = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_q == GW'(i)) begin
                req_g  = req[i];
                data_g = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        busy            = rst_n && (state_q == BURST);
        fifo_write      = busy && req_g && (fifo_free_space != '0);
        fifo_write_data = fifo_write ? data_g : '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            ack[i] = fifo_write && (grant_q == GW'(i));
        end
        grant_id = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    grant_d = pick;
                    last_d  = pick;
                    count_d = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // A stall (no free space) keeps both the grant and the count.
                if (!req_g) begin
                    state_d = IDLE;
                end else if (fifo_write) begin
                    if (count_q == CW'(MAX_BURST - 1)) begin
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(REQUESTERS - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

endmodule
